// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux
// Brief    : Multiplexed seven-segment driver with frame-latched data,
//            dead time, PWM brightness, per-digit blanking and hex decode.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_mux #(
  parameter int DIGITS   = 4,
  parameter int DIV_W    = 10,
  parameter int DEAD     = 16,
  parameter int BRIGHT_W = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [8*DIGITS-1:0]   i_data,
  input  logic                  i_hex_mode,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [BRIGHT_W-1:0]   i_bright,
  output logic [7:0]            o_data,
  output logic [DIGITS-1:0]     o_en,
  output logic                  o_frame
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] CNT_MAX  = '1;
  localparam logic [DIV_W-1:0] DEAD_C   = DIV_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [8*DIGITS-1:0] shadow_q, shadow_d;
  logic [7:0]          data_q, data_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                frame_q, frame_d;

  logic                slot_end;
  logic                frame_end;
  logic                lit;
  logic [7:0]          cur_byte;

  // Segment table, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end

    // Data is only sampled on the last clock of a frame so a frame never tears.
    shadow_d = frame_end ? i_data : shadow_q;
  end

  always_comb begin
    cur_byte = shadow_q[idx_q*8 +: 8];
    lit      = (cnt_q >= DEAD_C)
            && (cnt_q[DIV_W-1 -: BRIGHT_W] <= i_bright)
            && !i_blank[idx_q];

    en_d   = '1;
    data_d = 8'h00;
    if (lit) begin
      en_d[idx_q] = 1'b0;
      data_d      = i_hex_mode ? {cur_byte[7], hex_seg(cur_byte[3:0])} : cur_byte;
    end

    frame_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= 8'h00;
      en_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
    end
  end

  assign o_data  = data_q;
  assign o_en    = en_q;
  assign o_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_mux
// Brief    : Scoreboard bench: stimulus pushes expected outputs, monitor pops.
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        hex;
  logic [3:0]  blank;
  logic [1:0]  bright;
  logic [7:0]  o_data;
  logic [3:0]  o_en;
  logic        o_frame;

  int total = 0;
  int bad   = 0;

  logic [12:0] sb_q[$];

  int          m_cnt;
  int          m_idx;
  logic [31:0] m_shown;

  seven_seg_mux #(
    .DIGITS  (4),
    .DIV_W   (4),
    .DEAD    (2),
    .BRIGHT_W(2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_hex_mode(hex),
    .i_blank   (blank),
    .i_bright  (bright),
    .o_data    (o_data),
    .o_en      (o_en),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s t=%0t got en=%b data=%h frame=%b, required en=%b data=%h frame=%b",
                 name, $time, act[12:9], act[8:1], act[0], req[12:9], req[8:1], req[0]);
    end
  endtask

  // Called at a falling edge: predicts the outputs after the next rising edge.
  task automatic cyc();
    logic [3:0] en;
    logic [7:0] d;
    logic [7:0] b;
    logic       lit;
    if (rst) begin
      sb_q.push_back({4'hF, 8'h00, 1'b0});
      m_cnt   = 0;
      m_idx   = 0;
      m_shown = '0;
    end else begin
      b   = m_shown[m_idx*8 +: 8];
      lit = (m_cnt >= 2) && ((m_cnt / 4) <= int'(bright)) && !blank[m_idx];
      en  = 4'hF;
      d   = 8'h00;
      if (lit) begin
        en[m_idx] = 1'b0;
        d = hex ? {b[7], seg_ref(b[3:0])} : b;
      end
      sb_q.push_back({en, d, (m_cnt == 0) && (m_idx == 0)});
      if (m_cnt == 15) begin
        m_cnt = 0;
        if (m_idx == 3) begin
          m_idx   = 0;
          m_shown = data;
        end else begin
          m_idx++;
        end
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin : monitor
    logic [12:0] req;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        req = sb_q.pop_front();
        chk("out", {o_en, o_data, o_frame}, req);
      end
    end
  end

  initial begin : stim
    rst    = 1'b1;
    data   = 32'h0;
    hex    = 1'b0;
    blank  = 4'h0;
    bright = 2'd3;
    #2;
    chk("reset_state", {o_en, o_data, o_frame}, {4'hF, 8'h00, 1'b0});
    @(negedge clk);
    run(3);

    // Raw scan; first frame shows the zero shadow.
    rst  = 1'b0;
    data = 32'h44332211;
    run(128);

    // Hex decode, visible from the next frame.
    hex  = 1'b1;
    data = 32'h007F058A;
    run(128);

    // Brightness levels.
    bright = 2'd1;
    run(64);
    bright = 2'd0;
    run(64);
    bright = 2'd3;

    // Blank digit 2.
    blank = 4'b0100;
    run(64);
    blank = 4'b0000;

    // Mid-frame change must wait for the boundary.
    hex  = 1'b0;
    run(20);
    data = 32'hA1B2C3D4;
    run(100);

    // Change exactly on the boundary cycle, then change again right after.
    while (!(m_cnt == 15 && m_idx == 3)) cyc();
    data = 32'h5566EE77;
    cyc();
    data = 32'h99999999;
    run(64);

    // Asynchronous reset mid-slot while a digit is lit.
    while (m_cnt != 8) cyc();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {o_en, o_data, o_frame}, {4'hF, 8'h00, 1'b0});
    @(negedge clk);
    run(10);
    rst = 1'b0;
    run(80);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_mux.md
# seven_seg_mux

Parametrised multiplexed seven-segment display driver: the successor to the fixed 4-digit rotating driver. It scans DIGITS common-enable digits with a programmable slot length and anti-ghosting dead time. It offers raw-segment or hex-decode mode, per-digit blanking, PWM brightness, and tear-free frame-latched input data. It sits between register or interface logic holding display contents and the board's segment/enable pins.

## Interface
- DIGITS, 4: number of multiplexed digits (≥1).
- DIV_W, 10: slot length is 2**DIV_W clocks per digit.
- DEAD, 16: dark clocks at the start of each slot (anti-ghost); must satisfy DEAD < 2**DIV_W.
- BRIGHT_W, 3: brightness control width; must satisfy BRIGHT_W ≤ DIV_W.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  8*DIGITS  byte k drives digit k (bits 8k+7:8k).
  - Raw mode: byte is the segment pattern.
  - Hex mode: bits 3:0 are the hex value and bit 7 is the dp.
- i_hex_mode  in  1  1 = hex decode, 0 = raw segments.
- i_blank  in  DIGITS  bit k = 1 forces digit k dark.
- i_bright  in  BRIGHT_W  duty level; 0 = minimum lit, all-ones = full.
- o_data  out  8  segment outputs, active-high: bit0=a … bit6=g, bit7=dp.
- o_en  out  DIGITS  digit enables, active-low, at most one bit low.
- o_frame  out  1  one-cycle pulse marking start of digit 0's slot.

## Operation
- **Counters:**
  - cnt (DIV_W bits) increments every clock.
  - idx (0..DIGITS-1) advances when cnt = 2**DIV_W-1 and wraps from DIGITS-1 to 0. cnt wraps to 0 at the same time.
- **Shadow register:**
  - A shadow register (8*DIGITS) loads i_data only at the frame boundary (cnt = max and idx = DIGITS-1).
  - Mid-frame changes of i_data are never displayed until the next frame.
  - i_hex_mode, i_blank and i_bright are not shadowed; they take effect on the next clock.
- **Lit condition:** digit idx is lit when all of the following hold:
  - cnt ≥ DEAD;
  - cnt[DIV_W-1 -: BRIGHT_W] ≤ i_bright;
  - i_blank[idx] = 0.
- **When lit:** o_en = all ones except bit idx = 0.
  - o_data = shadow byte idx in raw mode.
  - In hex mode, o_data = {byte[7], seg(byte[3:0])}. The seg table, as {g..a} hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Bits 6:4 of the byte are ignored.
- **When not lit:** o_en = all ones and o_data = 8'h00. Segments are never driven while all enables are off.
- **o_frame:** high for exactly one cycle, corresponding to cnt = 0 and idx = 0.

## Timing
- **Reset values:** cnt = 0, idx = 0, shadow = 0, o_en = all ones, o_data = 8'h00, o_frame = 0. Reset takes effect immediately and asynchronously, including mid-slot.
- **First frame after reset:** displays the shadow value of 0. Raw mode is dark; hex mode shows "0" on every unblanked digit. i_data first appears from the second frame.
- **Latency:** all outputs are registered, one clock after the cnt/idx/control state they represent. The first lit cycle of a slot is the clock after cnt reaches DEAD.
- **Periods:** slot period is 2**DIV_W clocks; frame period is DIGITS·2**DIV_W clocks.
- **Single digit (DIGITS = 1):** idx stays 0, the frame boundary occurs every slot, and o_frame pulses every slot.
- **Simultaneous events:**
  - An i_data change on the frame-boundary cycle itself is captured.
  - An i_blank or i_bright change mid-slot alters the very next output cycle.

## Test plan
Parameters for all scenarios: DIGITS=4, DIV_W=4, DEAD=2, BRIGHT_W=2 (16-clock slot, 64-clock frame).

- **Reset:** assert i_rst mid-slot with a digit lit -> o_en=4'b1111 and o_data=00 immediately. Hold for 10 clocks with no change. After release, o_frame pulses once and outputs are dark for the first raw-mode frame.
- **Raw scan:** i_data=32'h44332211, raw mode, i_bright=3, i_blank=0, from the second frame -> each slot is 2 clocks of {1111, 00} then 14 clocks of lit data. Digit sequence: en 1110/data 11, then 1101/22, 1011/33, 0111/44, repeating every 64 clocks. o_frame is spaced exactly 64 clocks apart.
- **Hex decode:** hex mode, byte0=8'h8A, byte1=8'h05, byte2=8'h7F, byte3=8'h00 -> digit0 0xF7, digit1 0x6D, digit2 0x71, digit3 0x3F.
- **Brightness:** i_bright=1 -> lit for 6 clocks per slot (cnt 2..7). i_bright=0 -> lit for 2 clocks (cnt 2..3). i_bright=3 -> lit for 14 clocks.
- **Blanking:** i_blank=4'b0100 -> during digit 2's slot, o_en stays 1111 and o_data stays 00 for all 16 clocks; the other digits are unaffected.
- **Tear-free update:**
  - Change i_data mid-frame -> the displayed bytes stay old until the frame boundary, and all four digits switch together in the next frame.
  - Change i_data on the boundary cycle -> the new value is shown in the next frame.
